// File: rtl/victim_cache_pkg.sv
// Shared widths, state encoding and entry layout for the victim buffer.
package victim_cache_pkg;

    localparam int unsigned s_offset = 5;
    localparam int unsigned s_index  = 4;
    localparam int unsigned s_tag    = 32 - s_offset - s_index;
    localparam int unsigned s_line   = 256;
    localparam int unsigned s_depth  = 4;

    // Line address is {tag, index}; pointer indexes one of s_depth slots.
    localparam int unsigned s_addr = s_tag + s_index;
    localparam int unsigned s_ptr  = $clog2(s_depth);

    typedef enum logic {
        IDLE = 1'b0,
        WB   = 1'b1
    } vc_state_t;

    typedef struct packed {
        logic              valid;
        logic              dirty;
        logic [s_addr-1:0] addr;
        logic [s_line-1:0] data;
    } vc_entry_t;

endpackage

// File: rtl/victim_cam.sv
// Fully-associative address match across all victim entries.
module victim_cam
    import victim_cache_pkg::*;
(
    input  logic [s_depth-1:0][s_addr-1:0] entry_addr,
    input  logic [s_depth-1:0]             entry_valid,
    input  logic [s_addr-1:0]              lookup_addr,
    output logic [s_depth-1:0]             hit_vec,
    output logic                           hit,
    output logic [s_ptr-1:0]               hit_idx
);

    // Compare every valid entry; at most one can match, so OR-ing indices encodes it.
    always_comb begin
        hit_vec = '0;
        hit_idx = '0;
        for (int i = 0; i < int'(s_depth); i++) begin
            hit_vec[i] = entry_valid[i] && (entry_addr[i] == lookup_addr);
            if (hit_vec[i]) begin
                hit_idx = hit_idx | s_ptr'(i);
            end
        end
        hit = |hit_vec;
    end

endmodule

// File: rtl/victim_cache.sv
// Victim buffer: same-cycle lookup, insert/take/swap, dirty write-back on displacement.
module victim_cache
    import victim_cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              lookup,
    input  logic [s_addr-1:0] lookup_addr,
    output logic              lookup_hit,
    output logic [s_line-1:0] victim_data_o,
    output logic [s_tag-1:0]  victim_tag_o,
    output logic              victim_valid_o,
    output logic              victim_dirty_o,
    input  logic              take,
    input  logic              evict,
    input  logic [s_addr-1:0] evict_addr,
    input  logic [s_line-1:0] evict_data,
    input  logic              evict_dirty,
    output logic              evict_ready,
    output logic              busy,
    output logic [31:0]       pmem_address,
    output logic [s_line-1:0] pmem_wdata,
    output logic              pmem_write,
    input  logic              pmem_resp
);

    vc_entry_t [s_depth-1:0] entries_q, entries_d;
    vc_entry_t               stage_q, stage_d;
    logic [s_ptr-1:0]        rr_q, rr_d;
    vc_state_t               state_q, state_d;

    logic [s_depth-1:0][s_addr-1:0] cam_addr;
    logic [s_depth-1:0]             cam_valid;
    logic [s_depth-1:0]             hit_vec;
    logic                           cam_hit;
    logic [s_ptr-1:0]               hit_idx;
    logic                           free_found;
    logic [s_ptr-1:0]               free_idx;
    vc_entry_t                      new_entry;

    // Present stored addresses and valid bits to the match array.
    always_comb begin
        cam_addr  = '0;
        cam_valid = '0;
        for (int i = 0; i < int'(s_depth); i++) begin
            cam_addr[i]  = entries_q[i].addr;
            cam_valid[i] = entries_q[i].valid;
        end
    end

    victim_cam u_cam (
        .entry_addr  (cam_addr),
        .entry_valid (cam_valid),
        .lookup_addr (lookup_addr),
        .hit_vec     (hit_vec),
        .hit         (cam_hit),
        .hit_idx     (hit_idx)
    );

    // Lowest-numbered invalid slot wins; scan downward so the last write is the lowest.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = int'(s_depth) - 1; i >= 0; i--) begin
            if (!entries_q[i].valid) begin
                free_found = 1'b1;
                free_idx   = s_ptr'(i);
            end
        end
    end

    // Incoming line as it would be stored.
    always_comb begin
        new_entry       = '0;
        new_entry.valid = 1'b1;
        new_entry.dirty = evict_dirty;
        new_entry.addr  = evict_addr;
        new_entry.data  = evict_data;
    end

    // Lookup and write-back outputs; entries are hidden while a write-back is pending.
    always_comb begin
        busy           = (state_q == WB);
        evict_ready    = !busy;
        lookup_hit     = lookup && !busy && cam_hit;
        victim_valid_o = lookup_hit;
        victim_data_o  = '0;
        victim_tag_o   = '0;
        victim_dirty_o = 1'b0;
        if (lookup_hit) begin
            victim_data_o  = entries_q[hit_idx].data;
            victim_tag_o   = entries_q[hit_idx].addr[s_addr-1:s_index];
            victim_dirty_o = entries_q[hit_idx].dirty;
        end
        pmem_write   = busy;
        pmem_address = '0;
        pmem_wdata   = '0;
        // entry[rr] cannot change while busy, so driving from it keeps pmem outputs stable.
        if (busy) begin
            pmem_address = {entries_q[rr_q].addr, {s_offset{1'b0}}};
            pmem_wdata   = entries_q[rr_q].data;
        end
    end

    // Next-state: insert/take/swap in IDLE, install the staged line on write-back completion.
    always_comb begin
        entries_d = entries_q;
        stage_d   = stage_q;
        rr_d      = rr_q;
        state_d   = state_q;
        unique case (state_q)
            IDLE: begin
                if (lookup_hit && take && evict) begin
                    entries_d[hit_idx] = new_entry;
                end else if (evict) begin
                    if (free_found) begin
                        entries_d[free_idx] = new_entry;
                    end else if (!entries_q[rr_q].dirty) begin
                        entries_d[rr_q] = new_entry;
                        rr_d            = rr_q + s_ptr'(1);
                    end else begin
                        stage_d = new_entry;
                        state_d = WB;
                    end
                end else if (lookup_hit && take) begin
                    for (int i = 0; i < int'(s_depth); i++) begin
                        if (hit_vec[i]) begin
                            entries_d[i].valid = 1'b0;
                        end
                    end
                end
            end
            WB: begin
                if (pmem_resp) begin
                    entries_d[rr_q] = stage_q;
                    rr_d            = rr_q + s_ptr'(1);
                    state_d         = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset drops all entries and any staged line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entries_q <= '0;
            stage_q   <= '0;
            rr_q      <= '0;
            state_q   <= IDLE;
        end else begin
            entries_q <= entries_d;
            stage_q   <= stage_d;
            rr_q      <= rr_d;
            state_q   <= state_d;
        end
    end

endmodule

// File: tb/tb_victim_cache.sv
// Directed plus randomized bench for victim_cache against a slot-level reference model.
module tb_victim_cache;
    import victim_cache_pkg::*;

    localparam int AW = s_addr;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              lookup = 1'b0;
    logic [AW-1:0]     lookup_addr = '0;
    logic              lookup_hit;
    logic [s_line-1:0] victim_data_o;
    logic [s_tag-1:0]  victim_tag_o;
    logic              victim_valid_o;
    logic              victim_dirty_o;
    logic              take = 1'b0;
    logic              evict = 1'b0;
    logic [AW-1:0]     evict_addr = '0;
    logic [s_line-1:0] evict_data = '0;
    logic              evict_dirty = 1'b0;
    logic              evict_ready;
    logic              busy;
    logic [31:0]       pmem_address;
    logic [s_line-1:0] pmem_wdata;
    logic              pmem_write;
    logic              pmem_resp = 1'b0;

    victim_cache dut (
        .clk            (clk),
        .rst            (rst),
        .lookup         (lookup),
        .lookup_addr    (lookup_addr),
        .lookup_hit     (lookup_hit),
        .victim_data_o  (victim_data_o),
        .victim_tag_o   (victim_tag_o),
        .victim_valid_o (victim_valid_o),
        .victim_dirty_o (victim_dirty_o),
        .take           (take),
        .evict          (evict),
        .evict_addr     (evict_addr),
        .evict_data     (evict_data),
        .evict_dirty    (evict_dirty),
        .evict_ready    (evict_ready),
        .busy           (busy),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_write     (pmem_write),
        .pmem_resp      (pmem_resp)
    );

    always #5 clk = ~clk;

    // Reference model: slot contents, replacement pointer, pending write-back.
    bit          m_valid [s_depth];
    bit          m_dirty [s_depth];
    logic [AW-1:0]     m_addr [s_depth];
    logic [s_line-1:0] m_data [s_depth];
    int          m_rr;
    bit          m_wb;
    logic [AW-1:0]     s_addr_m;
    logic [s_line-1:0] s_data_m;
    bit          s_dirty_m;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int find(input logic [AW-1:0] a);
        for (int i = 0; i < int'(s_depth); i++) begin
            if (m_valid[i] && m_addr[i] == a) return i;
        end
        return -1;
    endfunction

    function automatic logic [s_line-1:0] dat(input int k);
        logic [31:0] w;
        w = 32'h1000_0000 + k;
        return {8{w}};
    endfunction

    function automatic logic [s_line-1:0] rnd256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [AW-1:0] pool(input int k);
        logic [31:0] v;
        v = k * 32'h0012_3441 + 32'h40;
        return v[AW-1:0];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(s_depth); i++) begin
            m_valid[i] = 0;
            m_dirty[i] = 0;
            m_addr[i]  = '0;
            m_data[i]  = '0;
        end
        m_rr = 0;
        m_wb = 0;
    endtask

    // Compare every output with what the model predicts for the current inputs.
    task automatic model_check();
        int hi;
        logic eh;
        logic [s_line-1:0] e_data;
        logic [s_tag-1:0] e_tag;
        logic e_dirty;
        logic [31:0] e_paddr;
        logic [s_line-1:0] e_pdata;
        hi = find(lookup_addr);
        eh = lookup && !m_wb && (hi >= 0);
        e_data = '0;
        e_tag = '0;
        e_dirty = 0;
        if (eh) begin
            e_data = m_data[hi];
            e_tag = m_addr[hi][AW-1:s_index];
            e_dirty = m_dirty[hi];
        end
        e_paddr = '0;
        e_pdata = '0;
        if (m_wb) begin
            e_paddr = {m_addr[m_rr], 5'b0};
            e_pdata = m_data[m_rr];
        end
        chk("lookup_hit", lookup_hit, eh);
        chk("victim_valid", victim_valid_o, eh);
        chk("victim_data", victim_data_o, e_data);
        chk("victim_tag", victim_tag_o, e_tag);
        chk("victim_dirty", victim_dirty_o, e_dirty);
        chk("busy", busy, m_wb);
        chk("evict_ready", evict_ready, !m_wb);
        chk("pmem_write", pmem_write, m_wb);
        chk("pmem_address", pmem_address, e_paddr);
        chk("pmem_wdata", pmem_wdata, e_pdata);
    endtask

    // Apply the buffer rules to the model for the inputs present at this edge.
    task automatic model_update();
        int hi;
        int fi;
        if (!m_wb) begin
            hi = lookup ? find(lookup_addr) : -1;
            if (hi >= 0 && take && evict) begin
                m_valid[hi] = 1; m_dirty[hi] = evict_dirty;
                m_addr[hi] = evict_addr; m_data[hi] = evict_data;
            end else if (evict) begin
                fi = -1;
                for (int i = int'(s_depth) - 1; i >= 0; i--) if (!m_valid[i]) fi = i;
                if (fi >= 0) begin
                    m_valid[fi] = 1; m_dirty[fi] = evict_dirty;
                    m_addr[fi] = evict_addr; m_data[fi] = evict_data;
                end else if (!m_dirty[m_rr]) begin
                    m_dirty[m_rr] = evict_dirty;
                    m_addr[m_rr] = evict_addr; m_data[m_rr] = evict_data;
                    m_rr = (m_rr + 1) % int'(s_depth);
                end else begin
                    s_addr_m = evict_addr; s_data_m = evict_data; s_dirty_m = evict_dirty;
                    m_wb = 1;
                end
            end else if (hi >= 0 && take) begin
                m_valid[hi] = 0;
            end
        end else if (pmem_resp) begin
            m_valid[m_rr] = 1; m_dirty[m_rr] = s_dirty_m;
            m_addr[m_rr] = s_addr_m; m_data[m_rr] = s_data_m;
            m_rr = (m_rr + 1) % int'(s_depth);
            m_wb = 0;
        end
    endtask

    task automatic apply(input logic lk, input logic [AW-1:0] la, input logic tk, input logic ev,
                         input logic [AW-1:0] ea, input logic [s_line-1:0] ed, input logic edy,
                         input logic rsp);
        @(negedge clk);
        lookup = lk; lookup_addr = la; take = tk; evict = ev;
        evict_addr = ea; evict_data = ed; evict_dirty = edy; pmem_resp = rsp;
        #1;
        model_check();
    endtask

    task automatic advance();
        model_update();
        @(posedge clk);
    endtask

    task automatic cyc(input logic lk, input logic [AW-1:0] la, input logic tk, input logic ev,
                       input logic [AW-1:0] ea, input logic [s_line-1:0] ed, input logic edy,
                       input logic rsp);
        apply(lk, la, tk, ev, ea, ed, edy, rsp);
        advance();
    endtask

    task automatic reset_check();
        @(negedge clk);
        rst = 1'b0; lookup = 1'b1; lookup_addr = 27'h20;
        take = 1'b0; evict = 1'b0; pmem_resp = 1'b0;
        #1;
        chk("rst_pmem_write", pmem_write, 0);
        chk("rst_busy", busy, 0);
        chk("rst_evict_ready", evict_ready, 1);
        chk("rst_lookup_hit", lookup_hit, 0);
        chk("rst_pmem_address", pmem_address, 0);
        chk("rst_pmem_wdata", pmem_wdata, 0);
        chk("rst_victim_data", victim_data_o, 0);
        chk("rst_victim_tag", victim_tag_o, 0);
        chk("rst_victim_valid", victim_valid_o, 0);
        chk("rst_victim_dirty", victim_dirty_o, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1; lookup = 1'b0;
    endtask

    localparam logic [s_line-1:0] A5 = {32{8'hA5}};

    initial begin
        logic lk, tk, ev, edy, rsp;
        logic [AW-1:0] la, ea;
        int hi, ex;

        model_reset();
        reset_check();

        // Fill an empty buffer with four clean lines.
        for (int i = 0; i < 4; i++) cyc(0, '0, 0, 1, AW'(32'h10 + i), dat(i), 0, 0);
        apply(1, 27'h12, 0, 0, '0, '0, 0, 0);
        chk("fill_hit", lookup_hit, 1);
        chk("fill_tag", victim_tag_o, 1);
        chk("fill_data", victim_data_o, dat(2));
        advance();

        // Clean displacement overwrites slot 0.
        cyc(0, '0, 0, 1, 27'h20, dat(4), 0, 0);
        apply(1, 27'h10, 0, 0, '0, '0, 0, 0);
        chk("clean_old_gone", lookup_hit, 0);
        advance();
        apply(1, 27'h20, 0, 0, '0, '0, 0, 0);
        chk("clean_new_hit", lookup_hit, 1);
        chk("clean_pmem_idle", pmem_write, 0);
        advance();

        // Make slot 1 dirty by swapping 0x11 with itself.
        cyc(1, 27'h11, 1, 1, 27'h11, A5, 1, 0);

        // Dirty displacement with pmem_resp delayed.
        cyc(0, '0, 0, 1, 27'h21, dat(5), 0, 0);
        apply(1, 27'h12, 0, 1, 27'h77, dat(9), 0, 0);
        chk("wb_busy", busy, 1);
        chk("wb_addr", pmem_address, 32'h220);
        chk("wb_data", pmem_wdata, A5);
        chk("wb_hidden", lookup_hit, 0);
        advance();
        for (int i = 0; i < 2; i++) begin
            apply(1, 27'h12, 0, 1, 27'h77, dat(9), 0, 0);
            chk("wb_ready_low", evict_ready, 0);
            advance();
        end
        apply(0, '0, 0, 0, '0, '0, 0, 1);
        chk("wb_resp_ready_low", evict_ready, 0);
        advance();
        apply(1, 27'h21, 0, 0, '0, '0, 0, 0);
        chk("wb_done_ready", evict_ready, 1);
        chk("wb_installed", lookup_hit, 1);
        chk("wb_installed_data", victim_data_o, dat(5));
        advance();
        apply(1, 27'h11, 0, 0, '0, '0, 0, 0);
        chk("wb_old_gone", lookup_hit, 0);
        advance();
        apply(1, 27'h77, 0, 0, '0, '0, 0, 0);
        chk("wb_evict_ignored", lookup_hit, 0);
        advance();

        // Swap 0x12 out for dirty 0x30.
        cyc(1, 27'h12, 1, 1, 27'h30, dat(6), 1, 0);
        apply(1, 27'h30, 0, 0, '0, '0, 0, 0);
        chk("swap_hit", lookup_hit, 1);
        chk("swap_dirty", victim_dirty_o, 1);
        chk("swap_no_wb", pmem_write, 0);
        advance();
        apply(1, 27'h12, 0, 0, '0, '0, 0, 0);
        chk("swap_old_gone", lookup_hit, 0);
        advance();

        // Take-only frees 0x13; refill that slot, then force a write-back of dirty 0x30.
        cyc(1, 27'h13, 1, 0, '0, '0, 0, 0);
        apply(1, 27'h13, 0, 0, '0, '0, 0, 0);
        chk("take_miss", lookup_hit, 0);
        advance();
        cyc(0, '0, 0, 1, 27'h40, dat(7), 0, 0);
        apply(0, '0, 0, 1, 27'h41, dat(8), 0, 0);
        chk("free_slot_no_wb", busy, 0);
        advance();
        apply(0, '0, 0, 0, '0, '0, 0, 0);
        chk("wb2_busy", busy, 1);
        chk("wb2_addr", pmem_address, 32'h600);
        advance();

        // Reset while the write-back is pending.
        reset_check();
        apply(1, 27'h20, 0, 0, '0, '0, 0, 0);
        chk("post_rst_miss", lookup_hit, 0);
        advance();
        apply(1, 27'h41, 0, 0, '0, '0, 0, 0);
        chk("post_rst_stage_lost", lookup_hit, 0);
        advance();

        // Randomized traffic over a small address pool.
        for (int n = 0; n < 600; n++) begin
            lk = ($urandom_range(0, 3) != 0);
            la = pool($urandom_range(0, 9));
            tk = $urandom_range(0, 1) != 0;
            ev = ($urandom_range(0, 2) == 0);
            ea = pool($urandom_range(0, 9));
            edy = $urandom_range(0, 1) != 0;
            rsp = m_wb ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            hi = (lk && !m_wb) ? find(la) : -1;
            ex = find(ea);
            // Keep addresses unique in the buffer, as the main cache guarantees.
            if (ex >= 0 && !(hi >= 0 && tk && ex == hi)) ev = 0;
            cyc(lk, la, tk, ev, ea, rnd256(), edy, rsp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
